// File: rtl/mag_cmp_seq.sv
// mag_cmp_seq: wide magnitude compare built from one shared external 4-bit comparator.
// Operands are walked a nibble per cycle from the MSB, stopping at the first unequal nibble.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, a, b         request and operands (captured on an accepted start)
//   busy, done          busy in RUN/DONE; done is a one-cycle result-valid pulse
//   gt, eq, lt          registered result, held until the next completion
//   cmp_a, cmp_b        nibble pair driven to the external comparator
//   cmp_gt/eq/lt        comparator answer, combinational in the same cycle
//
// Build option: define SIGNED_CMP_EN for two's complement operands
// (the sign nibble is offset-binary encoded on its way to the comparator).
module mag_cmp_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt,
    output logic [3:0]           cmp_a,
    output logic [3:0]           cmp_b,
    input  logic                 cmp_gt,
    input  logic                 cmp_eq,
    input  logic                 cmp_lt
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nxt;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic            accept;
    logic            res_load;
    logic            gt_nxt;
    logic            eq_nxt;
    logic            lt_nxt;
    logic [IW+1:0]   nib_base;

    // Bit offset of the current nibble (idx * 4).
    assign nib_base = {idx, 2'b00};

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        res_load  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    idx_nxt   = IDX_TOP;
                    accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (!cmp_eq || idx == '0) begin
                    state_nxt = S_DONE;
                    res_load  = 1'b1;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                idx_nxt   = IDX_TOP;
            end
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = IDX_TOP;
            end
        endcase
    end

    // Result decode. A non-one-hot comparator answer is a datapath
    // fault; gt wins over lt, which wins over eq. An all-zero answer
    // falls back to eq so the held result always stays one-hot.
    always_comb begin
        gt_nxt = 1'b0;
        eq_nxt = 1'b0;
        lt_nxt = 1'b0;
        if (cmp_gt) begin
            gt_nxt = 1'b1;
        end else if (cmp_lt) begin
            lt_nxt = 1'b1;
        end else begin
            eq_nxt = 1'b1;
        end
    end

    // Comparator operand mux; idle/done present zeros.
    always_comb begin
        cmp_a = 4'h0;
        cmp_b = 4'h0;
        if (state == S_RUN) begin
            cmp_a = a_lat[nib_base +: 4];
            cmp_b = b_lat[nib_base +: 4];
`ifdef SIGNED_CMP_EN
            // Flipping the sign bit maps two's complement onto
            // offset binary, so the unsigned compare orders signed.
            if (idx == IDX_TOP) begin
                cmp_a[3] = ~cmp_a[3];
                cmp_b[3] = ~cmp_b[3];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= IDX_TOP;
            a_lat <= '0;
            b_lat <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                a_lat <= a;
                b_lat <= b;
            end
            if (res_load) begin
                gt <= gt_nxt;
                eq <= eq_nxt;
                lt <= lt_nxt;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mag_cmp_seq.sv
// tb_mag_cmp_seq: scoreboard bench for mag_cmp_seq (NIBBLES=4).
// Stimulus pushes expected {gt,eq,lt} and done cycle; a monitor pops on done.
module tb_mag_cmp_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, gt, eq, lt;
    logic [3:0]  cmp_a, cmp_b;
    logic        cmp_gt, cmp_eq, cmp_lt;

    mag_cmp_seq #(.NIBBLES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt)
    );

    always #5 clk = ~clk;

    // Behavioural external comparator.
    always_comb begin
        cmp_gt = (cmp_a > cmp_b);
        cmp_eq = (cmp_a == cmp_b);
        cmp_lt = (cmp_a < cmp_b);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         at;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("result", {29'd0, gt, eq, lt}, {29'd0, e.res});
                check("done_cycle", cyc, e.at);
            end
        end
    end

    // Start one op at a negedge; returns at the negedge of RUN cycle 1.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [2:0] res, input int m);
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        e.res = res;
        e.at  = cyc + 1 + m;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sbq.size() != 0 || busy !== 1'b0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(k < 200), 32'd1);
        @(negedge clk);
    endtask

    logic [2:0] exp2;
    logic [7:0] tr0;

    initial begin
`ifdef SIGNED_CMP_EN
        exp2 = R_LT;
        tr0  = 8'h99;
`else
        exp2 = R_GT;
        tr0  = 8'h11;
`endif
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", {29'd0, gt, eq, lt}, 32'd0);
        check("rst_cmp", {24'd0, cmp_a, cmp_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: all nibbles equal, full walk.
        issue(16'hF00D, 16'hF00D, R_EQ, 4);
        check("t1_busy", 32'(busy), 32'd1);
        drain();

        // 2: MSB nibble differs; signedness decides.
        issue(16'h8000, 16'h7FFF, exp2, 1);
        drain();

        // 3: comparator trace 1/1, 2/2, 3/4 then zeros in DONE.
        issue(16'h1234, 16'h1244, R_LT, 3);
        check("t3_nib0", {24'd0, cmp_a, cmp_b}, {24'd0, tr0});
        @(negedge clk);
        check("t3_nib1", {24'd0, cmp_a, cmp_b}, 32'h22);
        @(negedge clk);
        check("t3_nib2", {24'd0, cmp_a, cmp_b}, 32'h34);
        @(negedge clk);
        check("t3_done_cmp", {24'd0, cmp_a, cmp_b}, 32'd0);
        drain();

        // 4: start while busy is ignored.
        issue(16'h0001, 16'h0000, R_GT, 4);
        a = 16'h0000;
        b = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // 5: reset in the second RUN cycle aborts silently.
        @(negedge clk);
        a = 16'hAAAA;
        b = 16'hAAAB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_res", {29'd0, gt, eq, lt}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_idle", 32'(busy), 32'd0);

        // 6: start held high, one done every 6 cycles.
        @(negedge clk);
        a = 16'h0000;
        b = 16'h0000;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.res = R_EQ;
            e.at  = cyc + 5 + 6 * i;
            sbq.push_back(e);
        end
        repeat (17) @(negedge clk);
        start = 1'b0;
        drain();

        check("queue_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
